// File: rtl/clk_div_prog_if.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Interface : clk_div_prog_if
// Brief     : Control and output bundle of the programmable clock divider.
//             The master side requests ratios and run state; the slave side
//             (the divider) returns the divided clock and status pulses.
// Revision  : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
  parameter int WIDTH = 8
) ();

  logic             enable;
  logic [WIDTH-1:0] div_ratio;
  logic             load;
  logic             oclk;
  logic             tick;
  logic             busy;
  logic             err;

  modport master (
    output enable,
    output div_ratio,
    output load,
    input  oclk,
    input  tick,
    input  busy,
    input  err
  );

  modport slave (
    input  enable,
    input  div_ratio,
    input  load,
    output oclk,
    output tick,
    output busy,
    output err
  );

endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Brief    : Programmable integer clock divider. Produces a 50% duty output
//            for even and odd ratios, applies ratio changes only at period
//            boundaries and stops cleanly at the end of a period.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_RATIO = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X     = (WIDTH+1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Rising-edge state
  state_t           state_q;
  logic [WIDTH-1:0] cnt;        // position inside the current output period
  logic [WIDTH-1:0] ratio_q;    // active divide ratio
  logic [WIDTH-1:0] pend_q;     // ratio waiting for the next period start
  logic             busy_q;
  logic             tick_q;
  logic             err_q;
  logic             p_q;        // high-phase of the output period

  // Falling-edge state: marks the second half of the last high cycle of an
  // odd period, so the output falls on a source falling edge.
  logic             n_q;

  // Next-state decode
  state_t           state_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] ratio_d;
  logic             last;
  logic             period_start;
  logic             legal;
  logic [WIDTH:0]   half_d;
  logic [WIDTH:0]   half_q;
  logic             p_d;
  logic             tick_d;

  // Period sequencing: advance, wrap, start or stop, and pick the ratio
  // that governs the period beginning at this edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt;
    ratio_d      = ratio_q;
    period_start = 1'b0;
    last         = (state_q == ST_RUN) && (cnt == (ratio_q - ONE));
    legal        = (bus.div_ratio >= MIN_RATIO);

    if (state_q == ST_IDLE) begin
      if (bus.enable) begin
        state_d      = ST_RUN;
        cnt_d        = '0;
        period_start = 1'b1;
      end
    end else if (last) begin
      cnt_d = '0;
      if (bus.enable) begin
        period_start = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      cnt_d = cnt + ONE;
    end

    if (period_start && busy_q) begin
      ratio_d = pend_q;
    end

    // Ratio is at least 2, so the subtraction never wraps; the extra bit
    // keeps ceil(N/2) exact for N = 2^WIDTH-1.
    half_d = ({1'b0, ratio_d} + ONE_X) >> 1;
    p_d    = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_d);
    tick_d = (state_d == ST_RUN) && (cnt_d == (ratio_d - ONE));
  end

  // Registered state and outputs on the source rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt     <= '0;
      ratio_q <= DEF_RATIO;
      pend_q  <= DEF_RATIO;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      ratio_q <= ratio_d;
      p_q     <= p_d;
      tick_q  <= tick_d;
      err_q   <= bus.load && !legal;
      // A legal load on the applying edge wins: it becomes the next pending
      // ratio and is applied one period later.
      if (bus.load && legal) begin
        pend_q <= bus.div_ratio;
        busy_q <= 1'b1;
      end else if (period_start) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign half_q = ({1'b0, ratio_q} + ONE_X) >> 1;

  // Half-cycle early drop for odd ratios, sampled on the source falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q && ratio_q[0] && ({1'b0, cnt} == (half_q - ONE_X));
    end
  end

  // p_q only changes on rising edges and n_q only on falling edges, so the
  // combination cannot glitch.
  assign bus.oclk = p_q && !n_q;
  assign bus.tick = tick_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule
`default_nettype wire
